// File: rtl/io_fifo_tester.sv
// io_fifo_tester: multi-channel 4-phase traffic generator and in-order checker for FIFO/link DUTs.
// Optional macro NS_TESTER_BACKPRESSURE_EN adds LFSR-driven sink acknowledge delays.
module io_fifo_tester #(
  parameter int NCH        = 2,
  parameter int DSZ        = 8,
  parameter int MIN_ADDR   = 0,
  parameter int MAX_ADDR   = 55,
  parameter int REF_ADDR   = 23,
  parameter int NUM_ROUNDS = 4
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic [NCH-1:0]     src_req,
  input  logic [NCH-1:0]     src_ack,
  output logic [NCH*DSZ-1:0] src_data,
  input  logic [NCH-1:0]     snk_req,
  output logic [NCH-1:0]     snk_ack,
  input  logic [NCH*DSZ-1:0] snk_data,
  output logic               o_done,
  output logic               o_err,
  output logic [3:0]         o_leds,
  output logic [3:0]         o_disp0,
  output logic [3:0]         o_disp1
);
  localparam int RW = 16;
  localparam logic [DSZ-1:0] MINV = DSZ'(MIN_ADDR);
  localparam logic [DSZ-1:0] MAXV = DSZ'(MAX_ADDR);
  localparam logic [DSZ-1:0] REFV = DSZ'(REF_ADDR);
  localparam logic [RW-1:0]  NRV  = RW'(NUM_ROUNDS);
  localparam logic [3:0]     NCHV = 4'(NCH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DONE} src_st_e;
  typedef enum logic [1:0] {K_WAIT, K_HOLD, K_ACK, K_DONE} snk_st_e;

  logic [NCH-1:0] mis, busy, sdone, kdone;
  logic [3:0]     got_ch [NCH+1];
  logic [3:0]     exp_ch [NCH+1];

  assign got_ch[NCH] = '0;
  assign exp_ch[NCH] = '0;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    src_st_e        sst_q;
    snk_st_e        kst_q;
    logic [DSZ-1:0] cnt_q, cnt_d, exp_q, exp_d, dat_q, got;
    logic [RW-1:0]  srnd_q, srnd_d, krnd_q, krnd_d;
    logic           req_q, ack_q, slast, klast;
`ifdef NS_TESTER_BACKPRESSURE_EN
    logic [7:0]     lfsr_q;
    logic [2:0]     dly_q;
`endif

    assign got = snk_data[c*DSZ +: DSZ];

    always_comb begin
      cnt_d  = (cnt_q == MAXV) ? MINV : cnt_q + DSZ'(1);
      srnd_d = (cnt_q == MAXV) ? srnd_q + RW'(1) : srnd_q;
      slast  = (cnt_q == MAXV) && (NUM_ROUNDS != 0) && (srnd_d == NRV);
      exp_d  = (exp_q == MAXV) ? MINV : exp_q + DSZ'(1);
      krnd_d = (exp_q == MAXV) ? krnd_q + RW'(1) : krnd_q;
      klast  = (exp_q == MAXV) && (NUM_ROUNDS != 0) && (krnd_d == NRV);
    end

    always_ff @(posedge i_clk) begin
      if (reset) begin
        sst_q  <= S_IDLE;
        req_q  <= 1'b0;
        dat_q  <= '0;
        cnt_q  <= MINV;
        srnd_q <= '0;
      end else begin
        case (sst_q)
          S_IDLE: begin
            sst_q <= S_REQ;
            req_q <= 1'b1;
            dat_q <= cnt_q;
          end
          S_REQ: if (src_ack[c]) begin
            sst_q <= S_REL;
            req_q <= 1'b0;
          end
          S_REL: if (!src_ack[c]) begin
            cnt_q  <= cnt_d;
            srnd_q <= srnd_d;
            if (slast) begin
              sst_q <= S_DONE;
            end else begin
              sst_q <= S_REQ;
              req_q <= 1'b1;
              dat_q <= cnt_d;
            end
          end
          default: req_q <= 1'b0;
        endcase
      end
    end

    always_ff @(posedge i_clk) begin
      if (reset) begin
        kst_q  <= K_WAIT;
        ack_q  <= 1'b0;
        exp_q  <= MINV;
        krnd_q <= '0;
`ifdef NS_TESTER_BACKPRESSURE_EN
        lfsr_q <= 8'hA5 ^ 8'(c);
        dly_q  <= '0;
`endif
      end else begin
        case (kst_q)
          K_WAIT: if (snk_req[c]) begin
`ifdef NS_TESTER_BACKPRESSURE_EN
            if (lfsr_q[2:0] == 3'd0) begin
              kst_q <= K_ACK;
              ack_q <= 1'b1;
            end else begin
              kst_q <= K_HOLD;
              dly_q <= lfsr_q[2:0] - 3'd1;
            end
`else
            kst_q <= K_ACK;
            ack_q <= 1'b1;
`endif
          end
`ifdef NS_TESTER_BACKPRESSURE_EN
          K_HOLD: begin
            if (dly_q == 3'd0) begin
              kst_q <= K_ACK;
              ack_q <= 1'b1;
            end else begin
              dly_q <= dly_q - 3'd1;
            end
          end
`endif
          K_ACK: if (!snk_req[c]) begin
            ack_q  <= 1'b0;
            exp_q  <= exp_d;
            krnd_q <= krnd_d;
            kst_q  <= klast ? K_DONE : K_WAIT;
`ifdef NS_TESTER_BACKPRESSURE_EN
            // Fibonacci LFSR, taps 8,6,5,4
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
          end
          default: ack_q <= 1'b0;
        endcase
      end
    end

    assign src_req[c]              = req_q;
    assign snk_ack[c]              = ack_q;
    assign src_data[c*DSZ +: DSZ]  = dat_q;
    assign mis[c]                  = (kst_q == K_WAIT) && snk_req[c] && (got != exp_q);
    assign busy[c]                 = (sst_q == S_REQ) || (sst_q == S_REL);
    assign sdone[c]                = (sst_q == S_DONE);
    assign kdone[c]                = (kst_q == K_DONE);
    // Priority chain from the top channel down so the lowest mismatching channel wins
    assign got_ch[c] = mis[c] ? got[3:0]   : got_ch[c+1];
    assign exp_ch[c] = mis[c] ? exp_q[3:0] : exp_ch[c+1];
  end

  logic       done_q, err_q, ref_q, busy_q, ref_hit0;
  logic [3:0] egot_q, eexp_q, disp0_q, disp1_q;

  assign ref_hit0 = (g_ch[0].kst_q == K_WAIT) && snk_req[0] && (snk_data[DSZ-1:0] == REFV);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ref_q   <= 1'b0;
      busy_q  <= 1'b0;
      egot_q  <= '0;
      eexp_q  <= '0;
      disp0_q <= '0;
      disp1_q <= '0;
    end else begin
      done_q <= (NUM_ROUNDS != 0) && (&sdone) && (&kdone);
      busy_q <= |busy;
      ref_q  <= ref_q | ref_hit0;
      if ((|mis) && !err_q) begin
        err_q  <= 1'b1;
        egot_q <= got_ch[0];
        eexp_q <= exp_ch[0];
      end
      if (err_q) begin
        disp0_q <= egot_q;
        disp1_q <= eexp_q;
      end else if (done_q) begin
        disp0_q <= NCHV;
        disp1_q <= g_ch[0].krnd_q[3:0];
      end else begin
        disp0_q <= g_ch[0].exp_q[3:0];
        disp1_q <= g_ch[0].krnd_q[3:0];
      end
    end
  end

  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_leds  = {ref_q, busy_q, err_q, done_q};
  assign o_disp0 = disp0_q;
  assign o_disp1 = disp1_q;
endmodule
